port_fifo_resp: RTL

PORT_FIFO_RESP -- requirements
Module: port_fifo_resp

---
 rtl/port_fifo_pkg.sv | 36 +++
 rtl/fifo_sync.sv | 57 +++++
 rtl/port_fifo_resp.sv | 112 +++++++++++
 3 files changed

// File: rtl/port_fifo_pkg.sv
// Register offsets, STATUS/CTRL bit positions and the offset decoder shared by
// the byte-port FIFO responder.
package port_fifo_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_TX_OVF   = 4;
    localparam int unsigned ST_RX_UDF   = 5;

    localparam int unsigned CTRL_CLR_FLAGS = 0;
    localparam int unsigned CTRL_FLUSH     = 1;

    typedef enum logic [1:0] {
        REG_DATA,
        REG_STATUS,
        REG_CTRL,
        REG_NONE
    } reg_sel_t;

    // Unaligned offsets fall through to REG_NONE, so they read 0 and ignore stores.
    function automatic reg_sel_t decode_off(input logic [3:0] off);
        case (off)
            OFF_DATA:   return REG_DATA;
            OFF_STATUS: return REG_STATUS;
            OFF_CTRL:   return REG_CTRL;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO; dout reads 0 while empty.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_MAX);
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/port_fifo_resp.sv
// Memory-mapped byte port: CPU stores feed a TX FIFO toward the device, device
// bytes land in an RX FIFO drained by CPU loads, with sticky overflow/underflow flags.
module port_fifo_resp
    import port_fifo_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] BASE  = 32'h800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    output logic        Hit,
    output logic [31:0] ReadData,
    output logic [7:0]  OutData,
    output logic        OutValid,
    input  logic        OutReady,
    input  logic [7:0]  InData,
    input  logic        InValid,
    output logic        InReady
);

    reg_sel_t    w_sel;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]  w_rx_dout;
    logic        w_data_wr, w_data_rd, w_ctrl_wr;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic        w_flush, w_clr_flags;
    logic        r_tx_ovf, r_rx_udf;
    logic [31:0] w_status;
    logic        w_unused;

    assign Hit   = (Adr[31:4] == BASE[31:4]);
    assign w_sel = decode_off(Adr[3:0]);

    assign w_data_wr = MemWrite & Hit & (w_sel == REG_DATA);
    assign w_data_rd = MemtoReg & Hit & (w_sel == REG_DATA);
    assign w_ctrl_wr = MemWrite & Hit & (w_sel == REG_CTRL);

    // Full/empty are sampled before this edge, so a same-cycle device pop cannot rescue a store.
    assign w_tx_push   = w_data_wr & ~w_tx_full;
    assign w_rx_pop    = w_data_rd & ~w_rx_empty;
    assign w_tx_pop    = OutValid & OutReady;
    assign w_rx_push   = InValid & InReady;
    assign w_flush     = w_ctrl_wr & WriteData[CTRL_FLUSH];
    assign w_clr_flags = w_ctrl_wr & WriteData[CTRL_CLR_FLAGS];

    assign OutValid = ~w_tx_empty;
    assign InReady  = ~w_rx_full;
    assign w_unused = ^WriteData[31:8];

    fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .flush (w_flush),
        .din   (WriteData[7:0]),
        .dout  (OutData),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .flush (w_flush),
        .din   (InData),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else if (w_clr_flags) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else begin
            if (w_data_wr && w_tx_full)  r_tx_ovf <= 1'b1;
            if (w_data_rd && w_rx_empty) r_rx_udf <= 1'b1;
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[ST_RX_UDF]   = r_rx_udf;
    end

    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (w_sel)
                REG_DATA:   ReadData = {24'b0, w_rx_dout};
                REG_STATUS: ReadData = w_status;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule
